gps_time_sequencer: RTL and testbench

//  Sits between GNRMC_Decode and Hc595_Pro. Validates each decoded UTC time and converts it to

---
 rtl/gps_time_sequencer_pkg.sv | 22 ++
 rtl/gps_time_sequencer_if.sv | 22 ++
 rtl/gps_time_sequencer_hms_counter.sv | 32 +++
 rtl/gps_time_sequencer.sv | 92 +++++++++
 tb/tb_gps_time_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/gps_time_sequencer_pkg.sv
// gps_time_sequencer_pkg: shared types, constants and digit conversions for the GPS time sequencer.
package gps_pkg;
    typedef enum logic [1:0] {IDLE, LOCKED, HOLDOVER} state_e;

    localparam logic [7:0]  ASCII_0   = 8'h30;
    localparam logic [23:0] BLANK_BCD = 24'hFFFFFF;

    function automatic logic is_digit(input logic [7:0] b);
        return b >= ASCII_0 && b <= ASCII_0 + 8'd9;
    endfunction

    // Only meaningful once both bytes pass is_digit; the low nibble of an ASCII digit is its value.
    function automatic logic [6:0] ascii2bin(input logic [15:0] pair);
        return 7'(pair[11:8]) * 7'd10 + 7'(pair[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return {t[3:0], 4'(v - t * 6'd10)};
    endfunction
endpackage

// File: rtl/gps_time_sequencer_if.sv
// gps_time_sequencer_if: decoded GPS frame input plus display handshake and status outputs.
interface gps_time_sequencer_if;
    logic        gps_valid;
    logic [15:0] hours;
    logic [15:0] minutes;
    logic [15:0] seconds;
    logic [23:0] disp_bcd;
    logic        disp_req;
    logic        disp_ack;
    logic        locked;
    logic        holdover;
    logic        fmt_err;

    modport master (
        input  gps_valid, hours, minutes, seconds, disp_ack,
        output disp_bcd, disp_req, locked, holdover, fmt_err
    );
    modport slave (
        output gps_valid, hours, minutes, seconds, disp_ack,
        input  disp_bcd, disp_req, locked, holdover, fmt_err
    );
endinterface

// File: rtl/gps_time_sequencer_hms_counter.sv
// hms_counter: binary hh:mm:ss with sync load and one-second increment, wrapping at midnight.
module hms_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       inc,
    input  logic [4:0] ld_hh,
    input  logic [5:0] ld_mm,
    input  logic [5:0] ld_ss,
    output logic [4:0] hh,
    output logic [5:0] mm,
    output logic [5:0] ss
);
    always_ff @(posedge clk) begin
        if (rst) begin
            hh <= '0;
            mm <= '0;
            ss <= '0;
        end else if (load) begin
            hh <= ld_hh;
            mm <= ld_mm;
            ss <= ld_ss;
        end else if (inc) begin
            ss <= ss == 6'd59 ? 6'd0 : ss + 6'd1;
            if (ss == 6'd59) begin
                mm <= mm == 6'd59 ? 6'd0 : mm + 6'd1;
                if (mm == 6'd59)
                    hh <= hh == 5'd23 ? 5'd0 : hh + 5'd1;
            end
        end
    end
endmodule

// File: rtl/gps_time_sequencer.sv
// gps_time_sequencer: validates GPS UTC frames, keeps local time with holdover, feeds the display via req/ack.
module gps_time_sequencer
    import gps_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TZ_OFFSET  = 8,
    parameter int HOLDOVER_S = 3,
    parameter int LOST_S     = 60
) (
    input logic                  clk,
    input logic                  rst,
    gps_time_sequencer_if.master bus
);
    localparam int CW = $clog2(CLK_HZ);
    localparam int SW = $clog2(LOST_S + 1);

    state_e        state, state_next;
    logic [CW-1:0] tick_cnt;
    logic [SW-1:0] silence;
    logic          tick, fmt_ok, good, upd, pending, disp_req;
    logic [23:0]   disp_bcd, image;
    logic [6:0]    h_utc, m_bin, s_bin, h_sum;
    logic [4:0]    hh;
    logic [5:0]    mm, ss;
    logic          fmt_err;

    assign tick   = tick_cnt == CW'(CLK_HZ - 1);
    assign h_utc  = ascii2bin(bus.hours);
    assign m_bin  = ascii2bin(bus.minutes);
    assign s_bin  = ascii2bin(bus.seconds);
    assign fmt_ok = is_digit(bus.hours[15:8]) && is_digit(bus.hours[7:0]) &&
                    is_digit(bus.minutes[15:8]) && is_digit(bus.minutes[7:0]) &&
                    is_digit(bus.seconds[15:8]) && is_digit(bus.seconds[7:0]) &&
                    h_utc <= 7'd23 && m_bin <= 7'd59 && s_bin <= 7'd59;
    assign good   = bus.gps_valid && fmt_ok;
    assign h_sum  = h_utc + 7'(TZ_OFFSET);

    // A load takes priority over a tick landing in the same cycle.
    hms_counter u_hms (
        .clk  (clk),
        .rst  (rst),
        .load (good),
        .inc  (tick && state != IDLE),
        .ld_hh(5'(h_sum >= 7'd24 ? h_sum - 7'd24 : h_sum)),
        .ld_mm(6'(m_bin)),
        .ld_ss(6'(s_bin)),
        .hh   (hh),
        .mm   (mm),
        .ss   (ss)
    );

    always_comb begin
        state_next = good ? LOCKED :
                     state == LOCKED   && silence == SW'(HOLDOVER_S) ? HOLDOVER :
                     state == HOLDOVER && silence == SW'(LOST_S)     ? IDLE : state;
        image = state == IDLE ? BLANK_BCD : {bin2bcd({1'b0, hh}), bin2bcd(mm), bin2bcd(ss)};
        upd   = good || (tick && state != IDLE) || state_next != state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            silence  <= '0;
            fmt_err  <= 1'b0;
            pending  <= 1'b0;
            disp_req <= 1'b0;
            disp_bcd <= BLANK_BCD;
        end else begin
            state    <= state_next;
            tick_cnt <= good || tick ? '0 : tick_cnt + 1'b1;
            silence  <= good ? '0 : tick && silence != SW'(LOST_S) ? silence + 1'b1 : silence;
            fmt_err  <= good ? 1'b0 : bus.gps_valid ? 1'b1 : fmt_err;
            // Updates arriving while a frame is in flight fold into one pending image.
            if (pending && !disp_req) begin
                disp_bcd <= image;
                disp_req <= 1'b1;
                pending  <= upd;
            end else begin
                pending <= pending || upd;
                if (bus.disp_ack)
                    disp_req <= 1'b0;
            end
        end
    end

    assign bus.disp_bcd = disp_bcd;
    assign bus.disp_req = disp_req;
    assign bus.locked   = state == LOCKED;
    assign bus.holdover = state == HOLDOVER;
    assign bus.fmt_err  = fmt_err;
endmodule

// File: tb/tb_gps_time_sequencer.sv
// tb_gps_time_sequencer: directed steps with random frame times checked against a seconds-of-day model.
module tb_gps_time_sequencer;
    localparam int TZ = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;
    int   e = 0;
    bit   auto_ack = 1'b0;
    int   t, tb_t;

    gps_time_sequencer_if bus();

    gps_time_sequencer #(
        .CLK_HZ(100), .TZ_OFFSET(TZ), .HOLDOVER_S(3), .LOST_S(60)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] exp_img(input int utc);
        int l, h, m, s;
        l = (utc + TZ * 3600) % 86400;
        h = l / 3600;
        m = (l / 60) % 60;
        s = l % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] pair(input int v);
        return {8'(48 + v / 10), 8'(48 + v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            e++;
            bus.disp_ack = auto_ack && bus.disp_req;
        end
    endtask

    task automatic send(input logic [15:0] h, input logic [15:0] m, input logic [15:0] s);
        bus.hours = h;
        bus.minutes = m;
        bus.seconds = s;
        bus.gps_valid = 1'b1;
        cyc(1);
        bus.gps_valid = 1'b0;
        e = 1;
    endtask

    task automatic frame(input int utc);
        send(pair(utc / 3600), pair((utc / 60) % 60), pair(utc % 60));
    endtask

    task automatic ack();
        bus.disp_ack = 1'b1;
        cyc(1);
        bus.disp_ack = 1'b0;
        chk("req_drop_after_ack", bus.disp_req, 0);
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget && !bus.disp_req; i++) cyc(1);
        chk("req_wait", bus.disp_req, 1);
    endtask

    initial begin
        bus.gps_valid = 1'b0;
        bus.hours = 16'h3030;
        bus.minutes = 16'h3030;
        bus.seconds = 16'h3030;
        bus.disp_ack = 1'b0;
        cyc(3);
        chk("rst_bcd", bus.disp_bcd, 24'hFFFFFF);
        chk("rst_req", bus.disp_req, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_holdover", bus.holdover, 0);
        chk("rst_fmt_err", bus.fmt_err, 0);
        rst = 1'b0;
        cyc(1);

        send(16'h3241, 16'h3030, 16'h3030);
        chk("bad_idle_fmt_err", bus.fmt_err, 1);
        chk("bad_idle_locked", bus.locked, 0);
        cyc(2);
        chk("bad_idle_req", bus.disp_req, 0);
        chk("bad_idle_bcd", bus.disp_bcd, 24'hFFFFFF);

        // 12:34:56 UTC shown as 20:34:56
        send(16'h3132, 16'h3334, 16'h3536);
        chk("lock_n1", bus.locked, 1);
        chk("req_n1", bus.disp_req, 0);
        cyc(1);
        chk("req_n2", bus.disp_req, 1);
        chk("bcd_n2", bus.disp_bcd, 24'h203456);
        chk("fmt_err_cleared", bus.fmt_err, 0);
        ack();

        t = 15 * 3600 + 59 * 60 + 59;
        frame(t);
        cyc(1);
        chk("pre_midnight", bus.disp_bcd, 24'h235959);
        ack();
        wait_req(150);
        chk("midnight_wrap", bus.disp_bcd, exp_img(t + 1));
        ack();

        send(16'h3241, 16'h3030, 16'h3030);
        chk("bad_hex_fmt_err", bus.fmt_err, 1);
        chk("bad_hex_locked", bus.locked, 1);
        cyc(2);
        chk("bad_hex_req", bus.disp_req, 0);
        chk("bad_hex_bcd", bus.disp_bcd, 24'h000000);
        t = $urandom_range(0, 86399);
        frame(t);
        chk("good_clears_fmt", bus.fmt_err, 0);
        cyc(1);
        chk("rand1_bcd", bus.disp_bcd, exp_img(t));
        ack();
        send(16'h3130, 16'h3630, 16'h3030);
        chk("bad_mm60_fmt_err", bus.fmt_err, 1);
        send(16'h3234, 16'h3030, 16'h3030);
        chk("bad_hh24_fmt_err", bus.fmt_err, 1);
        send(16'h3130, 16'h3030, 16'h353A);
        chk("bad_colon_fmt_err", bus.fmt_err, 1);
        cyc(2);
        chk("bad_keeps_bcd", bus.disp_bcd, exp_img(t));
        chk("bad_no_req", bus.disp_req, 0);

        t = $urandom_range(0, 86399);
        frame(t);
        chk("good2_clears_fmt", bus.fmt_err, 0);
        cyc(1);
        chk("busy_req", bus.disp_req, 1);
        while (e < 301) cyc(1);
        chk("frozen_bcd", bus.disp_bcd, exp_img(t));
        chk("frozen_req", bus.disp_req, 1);
        chk("locked_before_hold", bus.locked, 1);
        chk("no_hold_yet", bus.holdover, 0);
        cyc(1);
        chk("holdover_entry", bus.holdover, 1);
        ack();
        cyc(1);
        chk("collapsed_req", bus.disp_req, 1);
        chk("collapsed_newest", bus.disp_bcd, exp_img(t + 3));
        ack();
        auto_ack = 1'b1;
        while (e < 905) cyc(1);
        chk("holdover_runs", bus.disp_bcd, exp_img(t + 9));
        while (e < 6001) cyc(1);
        chk("hold_before_lost", bus.holdover, 1);
        cyc(1);
        chk("lost_holdover", bus.holdover, 0);
        chk("lost_locked", bus.locked, 0);
        cyc(10);
        chk("lost_blank", bus.disp_bcd, 24'hFFFFFF);
        chk("lost_req_idle", bus.disp_req, 0);

        t = $urandom_range(0, 86399);
        frame(t);
        chk("relock", bus.locked, 1);
        while (e < 100) cyc(1);
        tb_t = $urandom_range(0, 86399);
        frame(tb_t);
        cyc(4);
        chk("tick_load_no_inc", bus.disp_bcd, exp_img(tb_t));
        while (e < 99) cyc(1);
        chk("tick_restart_hold", bus.disp_bcd, exp_img(tb_t));
        while (e < 105) cyc(1);
        chk("tick_restart_inc", bus.disp_bcd, exp_img(tb_t + 1));

        auto_ack = 1'b0;
        cyc(2);
        frame($urandom_range(0, 86399));
        cyc(1);
        chk("req_before_rst", bus.disp_req, 1);
        rst = 1'b1;
        cyc(1);
        chk("rst_mid_req", bus.disp_req, 0);
        chk("rst_mid_bcd", bus.disp_bcd, 24'hFFFFFF);
        chk("rst_mid_locked", bus.locked, 0);
        rst = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
